// File: rtl/combo_keypad_if.sv
// Keypad front end of the combination lock: scans a 4x4 matrix, debounces, accumulates digits, compares with password.
// Optional failed-attempt lockout is built when KEYPAD_LOCKOUT_EN is defined.
module combo_keypad_if #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int DIGITS         = 4,
  parameter int LOCKOUT_TICKS  = 10000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            row_n,
  output logic [3:0]            col_n,
  input  logic                  setPW,
  input  logic                  attPW,
  output logic                  valid,
  output logic                  enter,
  output logic                  restart,
  output logic                  match,
  output logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   entry,
  output logic                  lockout
);

  localparam int TICK_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam int CNT_W  = $clog2(DIGITS + 1);

  localparam logic [1:0] S_SCAN    = 2'd0;
  localparam logic [1:0] S_DEBP    = 2'd1;
  localparam logic [1:0] S_PRESSED = 2'd2;

  logic [3:0]          row_s1_q, row_s2_q;
  logic [TICK_W-1:0]   tick_cnt_q;
  logic                tick;
  logic [1:0]          state_q, state_d;
  logic [3:0]          col_q, col_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic [1:0]          row_q, row_d;
  logic                press_ev, release_ev;
  logic                hit;
  logic [1:0]          hit_row, col_idx;
  logic [3:0]          code_now;
  logic                valid_q, enter_q, restart_q, match_q;
  logic [3:0]          key_code_q;
  logic [4*DIGITS-1:0] entry_q, pw_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                lockout_q, lock_start;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;
      4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;
      default: key_map = 4'h0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    row_s1_q <= row_n;
    row_s2_q <= row_s1_q;
  end

  assign tick = (tick_cnt_q == TICK_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) tick_cnt_q <= '0;
    else               tick_cnt_q <= tick_cnt_q + TICK_W'(1);
  end

  // Key decode: lowest low row wins; column 3 (A-D) and lockout count as no key.
  always_comb begin
    hit_row = 2'd0;
    case (col_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      default: col_idx = 2'd3;
    endcase
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2_q[r]) hit_row = 2'(r);
    end
    hit      = ~&row_s2_q && (col_idx != 2'd3) && !lockout_q;
    code_now = key_map(hit_row, col_idx);
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    deb_d      = deb_q;
    row_d      = row_q;
    press_ev   = 1'b0;
    release_ev = 1'b0;
    if (tick) begin
      case (state_q)
        S_SCAN: begin
          if (hit) begin
            state_d = S_DEBP;
            deb_d   = DEB_W'(1);
            row_d   = hit_row;
          end else begin
            col_d = {col_q[2:0], col_q[3]};
          end
        end
        S_DEBP: begin
          if (hit && hit_row == row_q) begin
            if (deb_q == DEB_W'(DEBOUNCE_SCANS - 1)) begin
              state_d  = S_PRESSED;
              deb_d    = '0;
              press_ev = 1'b1;
            end else begin
              deb_d = deb_q + DEB_W'(1);
            end
          end else begin
            state_d = S_SCAN;
            deb_d   = '0;
          end
        end
        S_PRESSED: begin
          if (hit) begin
            deb_d = '0;
          end else if (deb_q == DEB_W'(DEBOUNCE_SCANS - 1)) begin
            state_d    = S_SCAN;
            deb_d      = '0;
            release_ev = 1'b1;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
        default: begin
          state_d = S_SCAN;
          deb_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SCAN;
      col_q   <= 4'b1110;
      deb_q   <= '0;
      row_q   <= 2'd0;
    end else begin
      state_q <= lock_start ? S_SCAN : state_d;
      col_q   <= col_d;
      deb_q   <= lock_start ? '0 : deb_d;
      row_q   <= row_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      enter_q    <= 1'b0;
      restart_q  <= 1'b0;
      key_code_q <= 4'h0;
    end else if (press_ev) begin
      key_code_q <= code_now;
      valid_q    <= !lock_start;
      enter_q    <= !lock_start && (code_now == 4'hF);
      restart_q  <= !lock_start && (code_now == 4'hE);
    end else if (release_ev) begin
      valid_q   <= 1'b0;
      enter_q   <= 1'b0;
      restart_q <= 1'b0;
    end
  end

  // Clearing waits for the release so entry/match hold still while the FSM samples '#'/'*'.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
      pw_q    <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      if (press_ev && (code_now <= 4'h9) && (setPW || attPW)) begin
        entry_q <= {entry_q[4*DIGITS-5:0], code_now};
        if (cnt_q != CNT_W'(DIGITS)) cnt_q <= cnt_q + CNT_W'(1);
      end else if (release_ev && (key_code_q == 4'hE || key_code_q == 4'hF)) begin
        entry_q <= '0;
        cnt_q   <= '0;
      end
      if (press_ev && (code_now == 4'hF) && setPW) pw_q <= entry_q;
      match_q <= (cnt_q == CNT_W'(DIGITS)) && (entry_q == pw_q);
    end
  end

`ifdef KEYPAD_LOCKOUT_EN
  localparam int LOCK_W = $clog2(LOCKOUT_TICKS + 1);

  logic [1:0]        fail_q;
  logic [LOCK_W-1:0] lock_cnt_q;

  assign lock_start = press_ev && (code_now == 4'hF) && attPW && !match_q && (fail_q == 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      fail_q     <= 2'd0;
      lockout_q  <= 1'b0;
      lock_cnt_q <= '0;
    end else if (lockout_q) begin
      if (tick) begin
        if (lock_cnt_q == LOCK_W'(1)) begin
          lockout_q <= 1'b0;
          fail_q    <= 2'd0;
        end else begin
          lock_cnt_q <= lock_cnt_q - LOCK_W'(1);
        end
      end
    end else if (press_ev && (code_now == 4'hF) && attPW) begin
      if (match_q) begin
        fail_q <= 2'd0;
      end else if (fail_q == 2'd2) begin
        lockout_q  <= 1'b1;
        lock_cnt_q <= LOCK_W'(LOCKOUT_TICKS);
      end else begin
        fail_q <= fail_q + 2'd1;
      end
    end
  end
`else
  assign lock_start = 1'b0;
  assign lockout_q  = 1'b0;
`endif

  assign col_n    = col_q;
  assign valid    = valid_q;
  assign enter    = enter_q;
  assign restart  = restart_q;
  assign match    = match_q;
  assign key_code = key_code_q;
  assign entry    = entry_q;
  assign lockout  = lockout_q;

endmodule

// File: tb/tb_combo_keypad_if.sv
// Directed bench for combo_keypad_if with a matrix keypad model (SCAN_DIV=4, DEBOUNCE_SCANS=2, DIGITS=4, LOCKOUT_TICKS=20).
module tb_combo_keypad_if;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        setPW, attPW;
  logic        valid, enter, restart, match, lockout;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [15:0] keys;

  int vecs = 0;
  int errs = 0;

  bit          ok;
  logic [3:0]  kc;
  logic        en, rs, m0, m1, ma;
  logic [15:0] ent;

  combo_keypad_if #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .DIGITS(4), .LOCKOUT_TICKS(20)) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n), .setPW(setPW), .attPW(attPW),
    .valid(valid), .enter(enter), .restart(restart), .match(match), .key_code(key_code),
    .entry(entry), .lockout(lockout)
  );

  always #5 clk = ~clk;

  // Row r is pulled low when a held key in row r sits on the driven (low) column.
  always_comb begin
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
  end

  function automatic logic [15:0] km(input logic [3:0] k);
    case (k)
      4'h1: km = 16'h0001;  4'h2: km = 16'h0002;  4'h3: km = 16'h0004;
      4'h4: km = 16'h0010;  4'h5: km = 16'h0020;  4'h6: km = 16'h0040;
      4'h7: km = 16'h0100;  4'h8: km = 16'h0200;  4'h9: km = 16'h0400;
      4'hE: km = 16'h1000;  4'h0: km = 16'h2000;  4'hF: km = 16'h4000;
      default: km = 16'h0000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Hold mask until valid rises, release, wait for valid to fall; report what was seen.
  task automatic tap(input logic [15:0] mask, input bit col0_sync, output bit t_ok,
                     output logic [3:0] t_kc, output logic t_en, output logic t_rs,
                     output logic [15:0] t_ent, output logic t_m0, output logic t_m1, output logic t_ma);
    int n;
    t_ok = 1'b0; t_kc = 4'h0; t_en = 1'b0; t_rs = 1'b0; t_ent = 16'h0;
    t_m0 = 1'b0; t_m1 = 1'b0; t_ma = 1'b0;
    if (col0_sync) begin
      n = 0; while (col_n !== 4'b0111 && n < 100) begin step(); n++; end
      n = 0; while (col_n !== 4'b1110 && n < 100) begin step(); n++; end
    end
    keys = mask;
    n = 0; while (valid !== 1'b1 && n < 300) begin step(); n++; end
    if (valid === 1'b1) begin
      t_kc = key_code; t_en = enter; t_rs = restart; t_ent = entry; t_m0 = match;
      step();
      t_m1 = match; t_ma = t_m0 & t_m1;
      keys = 16'h0;
      n = 0; while (valid === 1'b1 && n < 300) begin t_ma &= match; step(); n++; end
      t_ok = (valid === 1'b0);
    end
    keys = 16'h0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    logic [3:0] exp_col [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    bit seen_v = 1'b0;
    reset = 1'b1; keys = 16'h0; setPW = 1'b0; attPW = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (col_n !== 4'b1110) begin errs++; $display("FAIL reset_col got %b want 1110", col_n); end
    vecs++; if ({valid, enter, restart, match, lockout} !== 5'b0) begin errs++; $display("FAIL reset_flags got %b want 00000", {valid, enter, restart, match, lockout}); end
    vecs++; if ({key_code, entry} !== 20'h0) begin errs++; $display("FAIL reset_data got %h/%h want 0/0000", key_code, entry); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (3) begin step(); seen_v |= valid; end
      vecs++; if (col_n !== exp_col[(i + 3) % 4]) begin errs++; $display("FAIL rot_hold%0d got %b want %b", i, col_n, exp_col[(i + 3) % 4]); end
      step(); seen_v |= valid;
      vecs++; if (col_n !== exp_col[i]) begin errs++; $display("FAIL rot_step%0d got %b want %b", i, col_n, exp_col[i]); end
    end
    vecs++; if (seen_v !== 1'b0) begin errs++; $display("FAIL idle_valid got 1 want 0"); end
  endtask

  task automatic test_bounce_press5();
    int n;
    bit seen_v = 1'b0;
    setPW = 1'b1;
    n = 0; while (col_n === 4'b1101 && n < 100) begin step(); n++; end
    n = 0; while (col_n !== 4'b1101 && n < 100) begin step(); n++; end
    keys = km(4'h5);
    repeat (4) begin step(); seen_v |= valid; end
    keys = 16'h0;
    repeat (6) begin step(); seen_v |= valid; end
    vecs++; if (seen_v !== 1'b0) begin errs++; $display("FAIL bounce_valid got 1 want 0"); end
    tap(km(4'h5), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
    vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL press5_handshake got %b want 1", ok); end
    vecs++; if (kc !== 4'h5) begin errs++; $display("FAIL press5_code got %h want 5", kc); end
    vecs++; if (ent !== 16'h0005) begin errs++; $display("FAIL press5_entry got %h want 0005", ent); end
    vecs++; if ({en, rs} !== 2'b00) begin errs++; $display("FAIL press5_enter_restart got %b want 00", {en, rs}); end
    vecs++; if (entry !== 16'h0005) begin errs++; $display("FAIL release5_entry got %h want 0005", entry); end
  endtask

  task automatic test_set_pw();
    logic [3:0] seq [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    setPW = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tap(km(seq[i]), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
      vecs++; if (kc !== seq[i] || ok !== 1'b1) begin errs++; $display("FAIL set_digit%0d got %h ok=%b want %h ok=1", i, kc, ok, seq[i]); end
    end
    vecs++; if (entry !== 16'h1234) begin errs++; $display("FAIL set_entry got %h want 1234", entry); end
    tap(km(4'hF), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
    vecs++; if ({ok, kc, en, rs} !== {1'b1, 4'hF, 1'b1, 1'b0}) begin errs++; $display("FAIL set_hash got ok=%b code=%h en=%b rs=%b want 1 f 1 0", ok, kc, en, rs); end
    vecs++; if (ent !== 16'h1234) begin errs++; $display("FAIL set_hash_entry got %h want 1234", ent); end
    vecs++; if ({entry, match} !== 17'h0) begin errs++; $display("FAIL set_clear got %h/%b want 0000/0", entry, match); end
    setPW = 1'b0;
  endtask

  task automatic test_match();
    logic [3:0] seq [9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h2, 4'h3, 4'h5, 4'h1};
    attPW = 1'b1;
    for (int i = 0; i < 4; i++) tap(km(seq[i]), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
    vecs++; if ({m0, m1} !== 2'b01) begin errs++; $display("FAIL match_lag got %b%b want 01", m0, m1); end
    tap(km(4'hF), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
    vecs++; if ({ok, en, ma} !== 3'b111) begin errs++; $display("FAIL match_hold got ok=%b en=%b match_all=%b want 111", ok, en, ma); end
    vecs++; if ({entry, match} !== 17'h0) begin errs++; $display("FAIL match_clear got %h/%b want 0000/0", entry, match); end
    for (int i = 4; i < 7; i++) tap(km(seq[i]), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
    vecs++; if ({entry, match} !== {16'h0123, 1'b0}) begin errs++; $display("FAIL match_short got %h/%b want 0123/0", entry, match); end
    tap(km(4'h5), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
    vecs++; if ({entry, match} !== {16'h1235, 1'b0}) begin errs++; $display("FAIL match_wrong got %h/%b want 1235/0", entry, match); end
    for (int i = 0; i < 4; i++) tap(km(seq[i]), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
    vecs++; if ({entry, match} !== {16'h1234, 1'b1}) begin errs++; $display("FAIL match_shift got %h/%b want 1234/1", entry, match); end
    attPW = 1'b0;
  endtask

  task automatic test_ignored_and_multi();
    bit seen_v = 1'b0;
    keys = 16'h0008;
    repeat (40) begin step(); seen_v |= valid; end
    keys = 16'h8000;
    repeat (40) begin step(); seen_v |= valid; end
    keys = 16'h0;
    repeat (12) step();
    vecs++; if (seen_v !== 1'b0) begin errs++; $display("FAIL letter_keys got valid=1 want 0"); end
    tap(km(4'h1) | km(4'h4), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
    vecs++; if ({ok, kc} !== {1'b1, 4'h1}) begin errs++; $display("FAIL low_row got ok=%b code=%h want 1 1", ok, kc); end
    vecs++; if (entry !== 16'h1234) begin errs++; $display("FAIL idle_digit got %h want 1234", entry); end
    tap(km(4'hE) | km(4'h0), 1'b1, ok, kc, en, rs, ent, m0, m1, ma);
    vecs++; if ({ok, kc, en, rs} !== {1'b1, 4'hE, 1'b0, 1'b1}) begin errs++; $display("FAIL star got ok=%b code=%h en=%b rs=%b want 1 e 0 1", ok, kc, en, rs); end
    vecs++; if ({ent, entry} !== {16'h1234, 16'h0000}) begin errs++; $display("FAIL star_clear got %h->%h want 1234->0000", ent, entry); end
  endtask

  task automatic test_lockout();
    int n;
    bit seen_v = 1'b0;
    attPW = 1'b1;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 4; i++) tap(km(4'h9), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
      vecs++; if ({entry, match} !== {16'h9999, 1'b0}) begin errs++; $display("FAIL wrong_entry%0d got %h/%b want 9999/0", t, entry, match); end
      if (t < 2) begin
        tap(km(4'hF), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
        vecs++; if ({ok, en, lockout} !== 3'b110) begin errs++; $display("FAIL fail_hash%0d got ok=%b en=%b lockout=%b want 1 1 0", t, ok, en, lockout); end
      end
    end
`ifdef KEYPAD_LOCKOUT_EN
    keys = km(4'hF);
    n = 0; while (lockout !== 1'b1 && n < 300) begin step(); n++; end
    vecs++; if ({lockout, valid} !== 2'b10) begin errs++; $display("FAIL lock_on got lockout=%b valid=%b want 1 0", lockout, valid); end
    keys = km(4'h5);
    repeat (48) begin step(); seen_v |= valid | enter | restart; end
    keys = 16'h0;
    vecs++; if ({seen_v, lockout} !== 2'b01) begin errs++; $display("FAIL lock_ignore got seen=%b lockout=%b want 0 1", seen_v, lockout); end
    n = 0; while (lockout !== 1'b0 && n < 200) begin step(); n++; end
    vecs++; if (lockout !== 1'b0) begin errs++; $display("FAIL lock_off got %b want 0", lockout); end
`else
    tap(km(4'hF), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
    vecs++; if ({ok, en, lockout} !== 3'b110) begin errs++; $display("FAIL no_lock got ok=%b en=%b lockout=%b want 1 1 0", ok, en, lockout); end
`endif
    tap(km(4'h5), 1'b0, ok, kc, en, rs, ent, m0, m1, ma);
    vecs++; if ({ok, kc, lockout} !== {1'b1, 4'h5, 1'b0}) begin errs++; $display("FAIL after_lock got ok=%b code=%h lockout=%b want 1 5 0", ok, kc, lockout); end
    attPW = 1'b0;
  endtask

  task automatic test_reset_mid_press();
    int n;
    bit seen_v = 1'b0;
    keys = km(4'h5);
    n = 0; while (valid !== 1'b1 && n < 300) begin step(); n++; end
    vecs++; if (valid !== 1'b1) begin errs++; $display("FAIL mid_press_valid got %b want 1", valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vecs++; if ({valid, col_n} !== {1'b0, 4'b1110}) begin errs++; $display("FAIL mid_reset got valid=%b col=%b want 0 1110", valid, col_n); end
    repeat (7) begin step(); seen_v |= valid; end
    vecs++; if (seen_v !== 1'b0) begin errs++; $display("FAIL redebounce got early valid want 0"); end
    n = 0; while (valid !== 1'b1 && n < 300) begin step(); n++; end
    vecs++; if ({valid, key_code} !== {1'b1, 4'h5}) begin errs++; $display("FAIL re_press got valid=%b code=%h want 1 5", valid, key_code); end
    keys = 16'h0;
    repeat (20) step();
  endtask

  initial begin
    test_reset();
    test_bounce_press5();
    test_set_pw();
    test_match();
    test_ignored_and_multi();
    test_lockout();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
